synch_byte_mask_sram_rsp: RTL

//  Single-port synchronous SRAM model with byte-strobe writes and a decoupled response channel.
//  - Parametrised read latency; a response FIFO honours rready backpressure.
//  - Credit-based aready gating, so no response is ever dropped.
//  - Used as the testbench and FPGA data/instruction memory behind LSU and bus adapters that stall on rready.

---
 rtl/synch_byte_mask_sram_rsp.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/synch_byte_mask_sram_rsp.sv
// Single-port synchronous SRAM with byte-strobe writes, a fixed-latency response pipeline and a
// credit-gated response FIFO. Define SRAM_OOR_ERR_EN to add the rerr out-of-range flag.
module synch_byte_mask_sram_rsp #(
    parameter int DATAW      = 32,
    parameter int ADDRW      = 7,
    parameter int DEPTH      = 2**ADDRW,
    parameter int RDLAT      = 1,
    parameter int RSPQ_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rstx,
    input  logic [DATAW-1:0]   adata,
    input  logic [ADDRW-1:0]   aaddr,
    input  logic               avalid,
    input  logic               awren,
    input  logic [DATAW/8-1:0] astrb,
    output logic               aready,
    output logic               rvalid,
    input  logic               rready,
    output logic [DATAW-1:0]   rdata
`ifdef SRAM_OOR_ERR_EN
    ,
    output logic               rerr
`endif
);

    localparam int NB = DATAW / 8;
`ifdef SRAM_OOR_ERR_EN
    localparam int RW = DATAW + 1;
`else
    localparam int RW = DATAW;
`endif
    localparam int QW = (RSPQ_DEPTH > 1) ? $clog2(RSPQ_DEPTH) : 1;
    localparam int CW = $clog2(RSPQ_DEPTH + 1);
    localparam logic [QW-1:0] QLAST = QW'(RSPQ_DEPTH - 1);
    localparam logic [CW-1:0] QMAX  = CW'(RSPQ_DEPTH);

    logic [DATAW-1:0] mem [DEPTH];
    logic [RW-1:0]    fifo [RSPQ_DEPTH];
    logic [RW-1:0]    pipe_rsp [RDLAT];
    logic [RDLAT-1:0] pipe_vld;
    logic [CW-1:0]    count;
    logic [CW-1:0]    fifo_cnt;
    logic [QW-1:0]    wr_ptr;
    logic [QW-1:0]    rd_ptr;
    logic [RW-1:0]    last_pop;
    logic [RW-1:0]    rsp;
    logic [RW-1:0]    head;
    logic [RW-1:0]    out_word;
    logic [DATAW-1:0] mask;
    logic [DATAW-1:0] old_word;
    logic [DATAW-1:0] rsp_data;
    logic             in_range;
    logic             accept;
    logic             push;
    logic             pop;

    assign in_range = ({1'b0, aaddr} < (ADDRW+1)'(DEPTH));
    assign aready   = (count < QMAX);
    assign accept   = avalid & aready;
    assign push     = pipe_vld[RDLAT-1];
    assign rvalid   = (fifo_cnt != '0);
    assign pop      = rvalid & rready;

    // The response word is formed at the accepting edge: merged word for writes, zero when out of range.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NB; i++) begin
            mask[8*i +: 8] = {8{astrb[i]}};
        end
        old_word = in_range ? mem[aaddr] : '0;
        rsp_data = '0;
        if (in_range) begin
            rsp_data = awren ? ((adata & mask) | (old_word & ~mask)) : old_word;
        end
    end

`ifdef SRAM_OOR_ERR_EN
    assign rsp = {~in_range, rsp_data};
`else
    assign rsp = rsp_data;
`endif

    always_ff @(posedge clk) begin
        if (accept && awren && in_range) begin
            mem[aaddr] <= rsp_data;
        end
    end

    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            pipe_vld <= '0;
            for (int i = 0; i < RDLAT; i++) begin
                pipe_rsp[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= accept;
            pipe_rsp[0] <= rsp;
            for (int i = RDLAT - 1; i > 0; i--) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_rsp[i] <= pipe_rsp[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= pipe_rsp[RDLAT-1];
        end
    end

    // Credits cover pipeline plus FIFO, so a push can never find the FIFO full.
    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            count    <= '0;
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            last_pop <= '0;
        end else begin
            if (accept && !pop) begin
                count <= count + CW'(1);
            end else if (!accept && pop) begin
                count <= count - CW'(1);
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + CW'(1);
            end else if (!push && pop) begin
                fifo_cnt <= fifo_cnt - CW'(1);
            end
            if (push) begin
                wr_ptr <= (wr_ptr == QLAST) ? '0 : wr_ptr + QW'(1);
            end
            if (pop) begin
                rd_ptr   <= (rd_ptr == QLAST) ? '0 : rd_ptr + QW'(1);
                last_pop <= head;
            end
        end
    end

    assign head     = fifo[rd_ptr];
    assign out_word = rvalid ? head : last_pop;
    assign rdata    = out_word[DATAW-1:0];
`ifdef SRAM_OOR_ERR_EN
    assign rerr     = out_word[DATAW];
`endif

endmodule
